// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester handshakes, responses and ALU port bundle.
// The arbiter takes the slave side; requesters/ALU sit on the master side.
interface alu_arbiter_if #(
   parameter int WIDTH = 32
);
   logic             req0_valid;
   logic             req0_ready;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic [3:0]       req0_ctrl;
   logic [4:0]       req0_shamt;
   logic             req1_valid;
   logic             req1_ready;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic [3:0]       req1_ctrl;
   logic [4:0]       req1_shamt;
   logic             resp0_valid;
   logic [WIDTH-1:0] resp0_out;
   logic             resp0_zero;
   logic             resp1_valid;
   logic [WIDTH-1:0] resp1_out;
   logic             resp1_zero;
   logic [WIDTH-1:0] ALU_reg_1;
   logic [WIDTH-1:0] ALU_reg_2;
   logic [3:0]       ALU_control;
   logic [4:0]       shamt;
   logic [WIDTH-1:0] ALU_out;
   logic             ALU_zero;
   logic             busy;

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_ctrl, req0_shamt,
      input  req1_valid, req1_a, req1_b, req1_ctrl, req1_shamt,
      input  ALU_out, ALU_zero,
      output req0_ready, req1_ready,
      output resp0_valid, resp0_out, resp0_zero,
      output resp1_valid, resp1_out, resp1_zero,
      output ALU_reg_1, ALU_reg_2, ALU_control, shamt,
      output busy
   );

   modport master (
      output req0_valid, req0_a, req0_b, req0_ctrl, req0_shamt,
      output req1_valid, req1_a, req1_b, req1_ctrl, req1_shamt,
      output ALU_out, ALU_zero,
      input  req0_ready, req1_ready,
      input  resp0_valid, resp0_out, resp0_zero,
      input  resp1_valid, resp1_out, resp1_zero,
      input  ALU_reg_1, ALU_reg_2, ALU_control, shamt,
      input  busy
   );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin share of one ALU between two requesters.
// Operands are registered onto the ALU, result captured after ALU_LAT cycles.
module alu_arbiter #(
   parameter int WIDTH   = 32,
   parameter int ALU_LAT = 1
) (
   input logic         clk,
   input logic         reset,
   alu_arbiter_if.slave bus
);
   typedef enum logic {IDLE, WAIT} state_t;

   localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

   state_t           state;
   state_t           state_nx;
   logic [3:0]       cnt;
   logic             owner;
   logic             last;
   logic             acc;
   logic             gnt;
   logic             cap;
   logic [WIDTH-1:0] res_out;
   logic             res_zero;
   logic             rv0;
   logic             rv1;
   logic [WIDTH-1:0] r1;
   logic [WIDTH-1:0] r2;
   logic [3:0]       rc;
   logic [4:0]       rs;

   // Grant selection, accept/capture strobes and next state.
   always_comb begin
      state_nx = state;
      acc      = 1'b0;
      gnt      = 1'b0;
      cap      = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.req0_valid && bus.req1_valid) begin
               acc = 1'b1;
               gnt = ~last;
            end else if (bus.req0_valid) begin
               acc = 1'b1;
               gnt = 1'b0;
            end else if (bus.req1_valid) begin
               acc = 1'b1;
               gnt = 1'b1;
            end
            if (acc) state_nx = WAIT;
         end
         WAIT: begin
            if (cnt == 4'd0) begin
               cap      = 1'b1;
               state_nx = IDLE;
            end
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Operand capture, latency counter, result capture and response pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         r1       <= '0;
         r2       <= '0;
         rc       <= 4'b0000;
         rs       <= 5'd0;
         cnt      <= 4'd0;
         owner    <= 1'b0;
         last     <= 1'b1;
         res_out  <= '0;
         res_zero <= 1'b0;
         rv0      <= 1'b0;
         rv1      <= 1'b0;
      end else begin
         rv0 <= cap & ~owner;
         rv1 <= cap & owner;
         if (acc) begin
            r1    <= gnt ? bus.req1_a     : bus.req0_a;
            r2    <= gnt ? bus.req1_b     : bus.req0_b;
            rc    <= gnt ? bus.req1_ctrl  : bus.req0_ctrl;
            rs    <= gnt ? bus.req1_shamt : bus.req0_shamt;
            cnt   <= CNT_INIT;
            owner <= gnt;
            last  <= gnt;
         end else if (state == WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
         if (cap) begin
            res_out  <= bus.ALU_out;
            res_zero <= bus.ALU_zero;
         end
      end
   end

   assign bus.req0_ready  = acc & ~gnt;
   assign bus.req1_ready  = acc & gnt;
   assign bus.resp0_valid = rv0;
   assign bus.resp1_valid = rv1;
   assign bus.resp0_out   = res_out;
   assign bus.resp1_out   = res_out;
   assign bus.resp0_zero  = res_zero;
   assign bus.resp1_zero  = res_zero;
   assign bus.ALU_reg_1   = r1;
   assign bus.ALU_reg_2   = r2;
   assign bus.ALU_control = rc;
   assign bus.shamt       = rs;
   assign bus.busy        = (state == WAIT);
endmodule
